// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag manager for a dual-clock FIFO.
// Keeps the binary/Gray write pointer, synchronizes the read Gray pointer, and derives full and occupancy.
module fifo_wptr_full #(
    parameter int addr_width_p  = 4,
    parameter int sync_stages_p = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [addr_width_p:0]   rptr_gray_i,
    output logic [addr_width_p-1:0] waddr_o,
    output logic [addr_width_p:0]   wptr_gray_o,
    output logic                    full_o,
    output logic [addr_width_p:0]   count_o
);

    localparam int A = addr_width_p;

    logic [A:0] wbin;
    logic [A:0] wbin_next;
    logic [A:0] gray_next;
    logic [A:0] wgray;
    logic [A:0] rsync;
    logic [A:0] rbin;
    logic [A:0] full_target;
    logic [A:0] sync_q [sync_stages_p];
    logic       push;
    logic       full;
    logic       full_next;

    assign push      = valid_i & ~full;
    assign wbin_next = wbin + {{A{1'b0}}, push};
    assign gray_next = wbin_next ^ (wbin_next >> 1);

    // Full when the write pointer is exactly one lap ahead: Gray form flips the top two bits.
    assign rsync       = sync_q[sync_stages_p-1];
    assign full_target = {~rsync[A:A-1], rsync[A-2:0]};
    assign full_next   = (gray_next == full_target);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wbin  <= '0;
            wgray <= '0;
            full  <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= gray_next;
            full  <= full_next;
        end
    end

    // Only the Gray pointer crosses the clock boundary.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < sync_stages_p; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray_i;
            for (int i = 1; i < sync_stages_p; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= A; i++) begin
            rbin[i] = ^(rsync >> i);
        end
    end

    assign waddr_o     = wbin[A-1:0];
    assign wptr_gray_o = wgray;
    assign full_o      = full;
    assign ready_o     = ~full;
    assign count_o     = wbin - rbin;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: a pointer-arithmetic model queues expected outputs per edge,
// a negedge monitor pops and compares them against the DUT.
module tb_fifo_wptr_full;

    localparam int A     = 4;
    localparam int S     = 2;
    localparam int DEPTH = 16;
    localparam int SPAN  = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid = 1'b0;
    logic [A:0]   rptr_gray = '0;
    logic         ready;
    logic [A-1:0] waddr;
    logic [A:0]   wptr_gray;
    logic         full;
    logic [A:0]   count;

    fifo_wptr_full #(.addr_width_p(A), .sync_stages_p(S)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .valid_i     (valid),
        .ready_o     (ready),
        .rptr_gray_i (rptr_gray),
        .waddr_o     (waddr),
        .wptr_gray_o (wptr_gray),
        .full_o      (full),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int waddr;
        int gray;
        int full;
        int count;
        bit step;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: write count modulo 2*DEPTH, read pointer delayed S edges.
    int m_w    = 0;
    int m_full = 0;
    int m_rs   = 0;
    int rin    = 0;
    int hist[$];
    int prev_gray = 0;

    function automatic int to_gray(input int b);
        int v;
        v = b % SPAN;
        return v ^ (v / 2);
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t snapshot(input bit step);
        exp_t e;
        e.waddr = m_w % DEPTH;
        e.gray  = to_gray(m_w);
        e.full  = m_full;
        e.count = (m_w - m_rs + SPAN) % SPAN;
        e.step  = step;
        return e;
    endfunction

    task automatic model_reset();
        m_w    = 0;
        m_full = 0;
        m_rs   = 0;
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(0);
    endtask

    task automatic model_edge();
        int pushed;
        int w_new;
        if (!reset) begin
            model_reset();
            exp_q.push_back(snapshot(1'b0));
        end else begin
            pushed = (valid && !m_full) ? 1 : 0;
            w_new  = (m_w + pushed) % SPAN;
            m_full = (((w_new - m_rs + SPAN) % SPAN) == DEPTH) ? 1 : 0;
            m_w    = w_new;
            hist.push_back(rin);
            void'(hist.pop_front());
            m_rs = hist[0];
            exp_q.push_back(snapshot(1'b1));
        end
    endtask

    // Entered just after a rising edge; leaves 1 time unit after the next one.
    task automatic cycle(input logic v, input int r);
        valid     = v;
        rin       = r % SPAN;
        rptr_gray = (A+1)'(to_gray(rin));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic async_reset(input string tag);
        #1 reset = 1'b0;
        #1;
        chk({tag, "_waddr"}, int'(waddr), 0);
        chk({tag, "_gray"},  int'(wptr_gray), 0);
        chk({tag, "_full"},  int'(full), 0);
        chk({tag, "_ready"}, int'(ready), 1);
        chk({tag, "_count"}, int'(count), 0);
        exp_q.delete();
        model_reset();
        exp_q.push_back(snapshot(1'b0));
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_waddr", int'(waddr), e.waddr);
            chk("sb_gray",  int'(wptr_gray), e.gray);
            chk("sb_full",  int'(full), e.full);
            chk("sb_ready", int'(ready), 1 - e.full);
            chk("sb_count", int'(count), e.count);
            if (e.step) chk("gray_one_bit", ($countones(int'(wptr_gray) ^ prev_gray) <= 1) ? 1 : 0, 1);
            prev_gray = int'(wptr_gray);
        end
    end

    initial begin
        int r;
        int occ;
        model_reset();

        for (int i = 0; i < 4; i++) cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, SPAN-1)));
        reset = 1'b1;
        cycle(1'b0, 0);
        cycle(1'b0, 0);

        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 0);
        chk("fill_full", int'(full), 1);
        chk("fill_gray", int'(wptr_gray), 'h18);
        chk("fill_count", int'(count), DEPTH);
        for (int i = 0; i < 5; i++) cycle(1'b1, 0);
        chk("held_gray", int'(wptr_gray), 'h18);
        chk("held_waddr", int'(waddr), 0);

        cycle(1'b0, 1);
        cycle(1'b0, 1);
        chk("free_j2_full", int'(full), 1);
        chk("free_j2_count", int'(count), DEPTH - 1);
        cycle(1'b0, 1);
        chk("free_j3_full", int'(full), 0);

        r = 1;
        for (int i = 0; i < 200; i++) begin
            occ = (m_w - r + SPAN) % SPAN;
            if (occ > 0 && $urandom_range(0, 2) == 0) r = (r + 1) % SPAN;
            cycle(1'($urandom_range(0, 1)), r);
        end

        async_reset("rst_a");
        for (int i = 0; i < 7; i++) cycle(1'b1, 0);
        chk("mid_count", int'(count), 7);
        async_reset("rst_b");
        cycle(1'b1, 0);
        chk("post_rst_waddr", int'(waddr), 1);

        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, m_w);
            chk("wrap_no_full", int'(full), 0);
            chk("wrap_count_le3", (int'(count) <= 3) ? 1 : 0, 1);
        end

        cycle(1'b0, m_w);
        cycle(1'b0, m_w);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-side pointer and full-flag manager for the dual-clock `fifo_1r1w_cdc`, sitting directly downstream of the up/down pointer counter.
- Tracks the write pointer in binary and Gray code and drives the RAM write address.
- Synchronizes the read domain's Gray pointer into the write clock domain.
- Produces a registered full flag, ready handshake and conservative occupancy count for the producer.
- The read-side twin mirrors it; this block covers only the write domain.

## Interface
- `addr_width_p`, default 4: log2 of FIFO depth. Legal range ≥ 2. Pointers are `addr_width_p+1` bits.
- `sync_stages_p`, default 2: flop stages in the read-pointer synchronizer. Legal range ≥ 2.
- `clk_i`  in  1  write-domain clock; all state is rising-edge.
- `reset_i`  in  1  reset, asynchronous and active-low.
  - 0 clears all state immediately.
  - Deassertion is synchronous to `clk_i`, provided externally.
- `valid_i`  in  1  producer push request.
- `ready_o`  out  1  space available; equals `~full_o`.
- `rptr_gray_i`  in  `addr_width_p+1`  read pointer in Gray code from the read domain; asynchronous to `clk_i`.
- `waddr_o`  out  `addr_width_p`  RAM write address, the low bits of the binary write pointer.
- `wptr_gray_o`  out  `addr_width_p+1`  registered Gray write pointer, exported to the read domain's synchronizer.
- `full_o`  out  1  registered full flag.
- `count_o`  out  `addr_width_p+1`  occupancy seen from the write side. Pessimistic: never under-reports.

## Operation
- Accept condition: `push = valid_i & ready_o`. When `full_o` = 1, `valid_i` is ignored and no state changes.
- Binary pointer `wbin`:
  - `wbin_next = wbin + push`, modulo 2^(`addr_width_p`+1); wrap is natural overflow.
  - `gray_next = wbin_next ^ (wbin_next >> 1)`.
  - Both are registered; `wptr_gray_o` is driven only from the flop, never combinationally.
- Synchronizer: `rptr_gray_i` passes through `sync_stages_p` flops, giving `rsync`. Only the Gray value crosses; no binary bits cross.
- Full compare:
  - `full_next = (gray_next == {~rsync[A:A-1], rsync[A-2:0]})`, with A = `addr_width_p`.
  - `full_next` is registered into `full_o`.
- Count:
  - `rbin` = Gray-to-binary of `rsync` (XOR prefix from the MSB).
  - `count_o = wbin − rbin`, modulo 2^(A+1), combinational from registers.
  - Range 0..2^A.
- Reset state (while `reset_i` = 0):
  - `wbin` = 0, `wptr_gray_o` = 0, `waddr_o` = 0.
  - All sync flops = 0.
  - `full_o` = 0, `ready_o` = 1, `count_o` = 0.
- Reset mid-operation: all of the above takes effect asynchronously. Pending pushes are dropped; no partial update.

## Timing
- Push latency: a push sampled at edge k updates `waddr_o`, `wptr_gray_o`, `count_o` and `full_o` right after edge k.
- The write that fills the last slot raises `full_o` on the same edge; the next cycle has `ready_o` = 0. No overflow is possible.
- Simultaneous push and read-pointer change: the push uses the current `rsync`. The new read pointer is reflected later, which is pessimistic and safe.
- Free latency: a change on `rptr_gray_i` (stable before edge j) reaches `rsync` after `sync_stages_p` edges, and `full_o` deasserts one edge after that. Total `sync_stages_p`+1 edges (3 at default).
- `wptr_gray_o` changes at most one bit per edge, including at wrap (binary 2^(A+1)−1 → 0).

## Test plan
- **Reset values:** hold `reset_i` = 0 with random `valid_i`/`rptr_gray_i`, then release and idle. Required: `waddr_o` = 0, `wptr_gray_o` = 0x00, `full_o` = 0, `ready_o` = 1, `count_o` = 0. Assert reset asynchronously between edges; outputs clear without waiting for a clock edge.
- **Fill to full** (A=4, `rptr_gray_i` = 0): 16 consecutive pushes. Required:
  - `waddr_o` steps 0..15 then 0.
  - After the 16th edge: `full_o` = 1, `ready_o` = 0, `wptr_gray_o` = 0x18, `count_o` = 16.
- **Push while full:** 5 further cycles of `valid_i` = 1. Required: no change to `wptr_gray_o` (0x18), `waddr_o` (0) or `count_o` (16).
- **Free latency:** at edge j set `rptr_gray_i` = 0x01 (read pointer 1). Required:
  - `full_o` stays 1 through edge j+2 and falls after edge j+3.
  - `count_o` = 15 after edge j+2.
- **Pointer wrap:** cycle pushes with `rptr_gray_i` tracking `wptr_gray_o` (FIFO kept near empty) through binary 31 → 0. Required:
  - `wptr_gray_o` goes 0x10 → 0x00.
  - Exactly one bit changes per push.
  - `full_o` never asserts; `count_o` ≤ 3.
- **Reset mid-fill:** after 7 pushes (`count_o` = 7), pulse `reset_i` low between edges. Required: all outputs return to reset values immediately, and the next push drives `waddr_o` 0 → 1.
